// File: rtl/ntt16_pkg.sv
// Shared constants, mode encodings and FSM state type for the 16-point
// transform stream controller.
package ntt16_pkg;

    localparam int NTT16_N = 16;
    localparam int NTT16_W = 16;
    localparam int NTT16_Q = 17;

    localparam logic MODE_NTT  = 1'b0;
    localparam logic MODE_INTT = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        UNLOAD
    } state_t;

endpackage

// File: rtl/ntt16_lane_buf.sv
// 16-lane register bank: indexed write, parallel load, parallel and indexed read.
// Parallel load takes priority over the indexed write.
module ntt16_lane_buf
    import ntt16_pkg::*;
#(
    parameter int W  = NTT16_W,
    parameter int N  = NTT16_N,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [IW-1:0]   wr_idx,
    input  logic [W-1:0]    wr_data,
    input  logic            ld_en,
    input  logic [N*W-1:0]  ld_data,
    input  logic [IW-1:0]   rd_idx,
    output logic [W-1:0]    rd_data,
    output logic [N*W-1:0]  par_data
);

    logic [N-1:0][W-1:0] lane;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane <= '0;
        end else if (ld_en) begin
            lane <= ld_data;
        end else if (wr_en) begin
            lane[wr_idx] <= wr_data;
        end
    end

    assign par_data = lane;
    assign rd_data  = lane[rd_idx];

endmodule

// File: rtl/ntt16_stream_ctrl.sv
// Deserialises a word stream onto the 16-lane core bus, waits out the core
// latency, captures the results and serialises them back out.
//   state  | meaning
//   IDLE   | waiting for lane 0 of a frame
//   LOAD   | accepting lanes 1..15
//   WAIT   | bus held stable for CORE_LAT cycles
//   UNLOAD | streaming captured results
module ntt16_stream_ctrl
    import ntt16_pkg::*;
#(
    parameter int W        = NTT16_W,
    parameter int N        = NTT16_N,
    parameter int Q        = NTT16_Q,
    parameter int CORE_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [W-1:0]    s_data,
    input  logic            s_mode,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [W-1:0]    m_data,
    output logic [3:0]      m_index,
    output logic            m_last,
    output logic            m_err,
    output logic            core_mode,
    output logic [N*W-1:0]  core_din,
    input  logic [N*W-1:0]  core_dout,
    output logic            busy
);

    localparam int CW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    state_t         state, state_nx;
    logic [3:0]     wr_idx, rd_idx, in_idx;
    logic [CW-1:0]  cnt;
    logic           frame_err;
    logic           s_fire, m_fire, capture, word_bad;
    logic [W-1:0]   in_rd_unused;
    logic [N*W-1:0] out_par_unused;

    assign s_fire   = s_valid & s_ready;
    assign m_fire   = m_valid & m_ready;
    assign capture  = (state == WAIT) && (cnt == CW'(CORE_LAT - 1));
    assign word_bad = (s_data >= W'(Q));
    assign in_idx   = (state == IDLE) ? 4'd0 : wr_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (s_fire) state_nx = LOAD;
            LOAD:    if (s_fire && wr_idx == 4'(N - 1)) state_nx = WAIT;
            WAIT:    if (capture) state_nx = UNLOAD;
            UNLOAD:  if (m_fire && rd_idx == 4'(N - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state == IDLE) || (state == LOAD);
        m_valid = (state == UNLOAD);
        busy    = (state != IDLE);
        m_last  = (state == UNLOAD) && (rd_idx == 4'(N - 1));
    end

    // Index counters wrap 15 -> 0, leaving them at 0 between frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx    <= '0;
            rd_idx    <= '0;
            cnt       <= '0;
            frame_err <= 1'b0;
            m_err     <= 1'b0;
            core_mode <= MODE_NTT;
        end else begin
            if (s_fire) begin
                if (state == IDLE) begin
                    core_mode <= s_mode;
                    frame_err <= word_bad;
                    wr_idx    <= 4'd1;
                end else begin
                    frame_err <= frame_err | word_bad;
                    wr_idx    <= wr_idx + 4'd1;
                end
            end
            if (state == WAIT) begin
                cnt <= capture ? '0 : cnt + CW'(1);
            end
            if (capture) begin
                m_err  <= frame_err;
                rd_idx <= '0;
            end else if (m_fire) begin
                rd_idx <= rd_idx + 4'd1;
            end
        end
    end

    ntt16_lane_buf #(.W(W), .N(N)) u_in_lanes (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (s_fire),
        .wr_idx   (in_idx),
        .wr_data  (s_data),
        .ld_en    (1'b0),
        .ld_data  ('0),
        .rd_idx   (4'd0),
        .rd_data  (in_rd_unused),
        .par_data (core_din)
    );

    ntt16_lane_buf #(.W(W), .N(N)) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (1'b0),
        .wr_idx   (4'd0),
        .wr_data  ('0),
        .ld_en    (capture),
        .ld_data  (core_dout),
        .rd_idx   (rd_idx),
        .rd_data  (m_data),
        .par_data (out_par_unused)
    );

    assign m_index = rd_idx;

endmodule

// File: doc/ntt16_stream_ctrl.md
# ntt16_stream_ctrl

Streaming controller for the 16-point modular transform datapath (q = 17, 16-bit lanes). It deserialises 16 coefficients from a valid/ready input stream onto the core's parallel input bus and selects forward NTT or INTT per frame. It holds the bus stable for the core's fixed latency, captures the 16 parallel results, and serialises them onto a valid/ready output stream. It sits between the host/DMA word stream and the combinational-plus-registered 16-point core, which is instantiated beside it, not inside it.

## Interface
- W, 16: lane width in bits.
- N, 16: points per frame; fixed at 16 by the core.
- Q, 17: modulus; used only for the range check.
- CORE_LAT, 2: core latency in cycles from stable inputs to valid outputs; must be ≥ 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  controller accepts an input word.
- s_data  in  W  input coefficient; the first beat of a frame is lane 0.
- s_mode  in  1  0 = forward NTT, 1 = INTT; sampled on the first beat of a frame only.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts an output word.
- m_data  out  W  result coefficient.
- m_index  out  4  lane number of m_data.
- m_last  out  1  high with lane 15.
- m_err  out  1  the current output frame contained an input word ≥ Q.
- core_mode  out  1  mode to the core.
- core_din  out  N*W  lane k occupies bits [k*W +: W].
- core_dout  in  N*W  core results, same packing.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, LOAD, WAIT, UNLOAD.
- IDLE:
  - s_ready = 1.
  - A handshake writes lane 0, latches s_mode into core_mode, clears the frame error, sets wr_idx = 1, and moves to LOAD.
- LOAD:
  - s_ready = 1.
  - Each handshake writes lane wr_idx and increments wr_idx.
  - The handshake on lane 15 moves to WAIT with cnt = 0.
  - Gaps in s_valid are allowed; lanes hold their values.
- Range check: any accepted word ≥ Q sets the frame error flag. The word is still passed unchanged to the core. The flag is copied to m_err at capture.
- WAIT:
  - s_ready = 0.
  - core_din and core_mode are held constant.
  - cnt increments each cycle.
  - When cnt = CORE_LAT−1, core_dout is captured into the output buffer and the state moves to UNLOAD with rd_idx = 0.
- UNLOAD:
  - s_ready = 0; m_valid = 1.
  - m_data = lane rd_idx, m_index = rd_idx, m_last = (rd_idx == 15).
  - A handshake increments rd_idx. The handshake on lane 15 returns to IDLE.
  - Input words presented during WAIT/UNLOAD are not accepted and remain pending upstream.
- core_din lanes are registers. They are not cleared between frames; they are overwritten.
- No arithmetic is performed here. The transform and the 1/N scaling are inside the core.

## Timing
- Reset values: state IDLE, s_ready 1, m_valid 0, m_data 0, m_index 0, m_last 0, m_err 0, core_mode 0, core_din 0, busy 0, all counters 0.
- Reset mid-frame, in any state, discards the frame in one cycle. The output buffer is zeroed, and no partial frame is ever emitted.
- Lane 15 accepted at edge E:
  - WAIT occupies CORE_LAT cycles.
  - Capture happens at edge E+CORE_LAT.
  - m_valid is first high in the cycle after edge E+CORE_LAT.
- With no backpressure, the output frame lasts 16 cycles. Frame period minimum = 16 + CORE_LAT + 16 cycles.
- m_data, m_index, m_last and m_err are registered and stable while m_valid = 1 and m_ready = 0.
- A handshake on lane 15 returns to IDLE at that edge, so s_ready = 1 in the very next cycle.
- s_mode is ignored on every beat except the first. Changing it mid-frame has no effect.

## Structure
- Package ntt16_pkg:
  - Constants NTT16_N = 16, NTT16_W = 16, NTT16_Q = 17.
  - Mode encodings MODE_NTT = 1'b0, MODE_INTT = 1'b1.
  - State enum {IDLE, LOAD, WAIT, UNLOAD}.
- Sub-module ntt16_lane_buf: a 16×W register bank with a synchronous indexed write, a parallel load, a full parallel read, and an indexed read. It is instantiated twice, as the input lanes and the output buffer.
- The FSM, counters and range check live in the top level.

## Test plan
- INTT round trip (core = INTT, s_mode = 1): stream 6,9,8,8,16,8,15,15,3,9,16,2,16,10,1,13 → m_data 15,2,16,10,7,5,6,16,10,4,0,5,8,11,2,8; m_last only on index 15; m_err = 0.
- Forward NTT (s_mode = 0): stream 15,2,16,10,7,5,6,16,10,4,0,5,8,11,2,8 → 6,9,8,8,16,8,15,15,3,9,16,2,16,10,1,13; m_valid first high exactly CORE_LAT cycles after the lane-15 edge.
- Backpressure: s_valid toggled 1/0 on input; m_ready low for 3 cycles at index 5 → m_data held at lane 5; output values are unchanged versus the first test.
- Range error: lane 3 = 17 → m_err = 1 for the whole output frame. The next frame, with all words < 17, produces m_err = 0.
- Reset mid-frame: assert rst after 7 accepted words → next cycle busy = 0, s_ready = 1, m_valid = 0. A full frame then streamed produces the correct result with no residue.
- Back-to-back frames, second with s_mode toggled mid-frame → the second frame uses the first-beat mode; s_ready = 0 throughout WAIT/UNLOAD.
